// File: rtl/ipv4_packet_tx_param.sv
// ipv4_packet_tx_param: parametrised IPv4 transmit framer.
// Latches one result message plus addressing and streams an Ethernet II header,
// a 20-byte IPv4 header and the payload over an AXI-S style valid/ready byte bus.
// Optional feature macro: IPV4_TX_MIN_FRAME_PAD_EN (pads short frames to 60 bytes).
module ipv4_packet_tx_param #(
    parameter int          MSG_WIDTH  = 10,
    parameter logic [7:0]  TTL        = 8'h80,
    parameter logic [7:0]  PROTOCOL   = 8'h04,
    parameter logic [15:0] IDENT_INIT = 16'h0
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]          ACCELERATOR_MAC_ADDRESS,
    input  logic [31:0]          RECIPIENT_IP_ADDRESS,
    input  logic [47:0]          RECIPIENT_MAC_ADDRESS,
    input  logic [MSG_WIDTH-1:0] RECIPIENT_MESSAGE,
    input  logic                 START_IP_TXN,
    output logic                 READY_FOR_SEND,
    output logic [7:0]           MAC_DATA_OUT,
    input  logic                 MAC_DATA_READY,
    output logic                 MAC_DATA_VALID,
    output logic                 MAC_DATA_FIRST,
    output logic                 MAC_DATA_LAST,
    output logic [15:0]          TX_PACKET_COUNT
);

    localparam int          PB        = (MSG_WIDTH + 7) / 8;
    localparam int          MSG_EXT_W = 8 * PB;
    localparam logic [15:0] TOTAL_LEN = 16'(20 + PB);
    localparam logic [15:0] PB_LAST   = 16'(PB - 1);
`ifdef IPV4_TX_MIN_FRAME_PAD_EN
    localparam int          PAD_BYTES = (34 + PB < 60) ? (26 - PB) : 0;
    localparam logic [15:0] PAD_LAST  = 16'(PAD_BYTES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ETH,
        S_IP,
`ifdef IPV4_TX_MIN_FRAME_PAD_EN
        S_PAD,
`endif
        S_PAY
    } state_t;

    state_t                 state, nstate;
    logic [15:0]            cnt, ncnt;
    logic [7:0]             data_r, nbyte;
    logic                   valid_r, first_r, last_r, rfs_r, nlast;
    logic [15:0]            pkt_cnt, ident_r;
    logic [47:0]            dst_mac_r, src_mac_r, dst_mac_sel, src_mac_sel;
    logic [31:0]            dst_ip_r, src_ip_r;
    logic [MSG_WIDTH-1:0]   msg_r;
    logic [MSG_EXT_W-1:0]   msg_ext;
    logic [15:0]            cks_acc, cks_word;
    logic [16:0]            cks_sum;
    logic [3:0]             cks_idx;
    logic [111:0]           eth_hdr;
    logic [159:0]           ip_hdr;

    assign READY_FOR_SEND  = rfs_r;
    assign MAC_DATA_OUT    = data_r;
    assign MAC_DATA_VALID  = valid_r;
    assign MAC_DATA_FIRST  = first_r;
    assign MAC_DATA_LAST   = last_r;
    assign TX_PACKET_COUNT = pkt_cnt;

    // Header word feeding the checksum accumulator this cycle (checksum field counts as zero)
    always_comb begin
        cks_word = '0;
        case (cks_idx)
            4'd0: cks_word = 16'h4500;
            4'd1: cks_word = TOTAL_LEN;
            4'd2: cks_word = ident_r;
            4'd4: cks_word = {TTL, PROTOCOL};
            4'd6: cks_word = src_ip_r[31:16];
            4'd7: cks_word = src_ip_r[15:0];
            4'd8: cks_word = dst_ip_r[31:16];
            4'd9: cks_word = dst_ip_r[15:0];
            default: cks_word = '0;
        endcase
        cks_sum = {1'b0, cks_acc} + {1'b0, cks_word};
    end

    // Next stream position and the byte/LAST flag to register for it.
    // In IDLE only byte 0 is produced, and the MACs are not yet latched, so take them from the ports.
    always_comb begin
        nstate = state;
        ncnt   = cnt + 16'd1;
        case (state)
            S_IDLE: begin nstate = S_ETH; ncnt = '0; end
            S_ETH:  if (cnt == 16'd13) begin nstate = S_IP; ncnt = '0; end
            S_IP:   if (cnt == 16'd19) begin nstate = S_PAY; ncnt = '0; end
`ifdef IPV4_TX_MIN_FRAME_PAD_EN
            S_PAY:  if (cnt == PB_LAST) begin nstate = S_PAD; ncnt = '0; end
            S_PAD:  nstate = S_PAD;
`else
            S_PAY:  if (cnt == PB_LAST) begin nstate = S_IDLE; ncnt = '0; end
`endif
            default: begin nstate = S_IDLE; ncnt = '0; end
        endcase

        dst_mac_sel = (state == S_IDLE) ? RECIPIENT_MAC_ADDRESS : dst_mac_r;
        src_mac_sel = (state == S_IDLE) ? ACCELERATOR_MAC_ADDRESS : src_mac_r;
        eth_hdr = {dst_mac_sel, src_mac_sel, 16'h0800};
        ip_hdr  = {16'h4500, TOTAL_LEN, ident_r, 16'h0000, TTL, PROTOCOL,
                   ~cks_acc, src_ip_r, dst_ip_r};
        msg_ext = MSG_EXT_W'(msg_r);

        nbyte = '0;
        case (nstate)
            S_ETH:   nbyte = eth_hdr[8*(13 - int'(ncnt)) +: 8];
            S_IP:    nbyte = ip_hdr[8*(19 - int'(ncnt)) +: 8];
            S_PAY:   nbyte = msg_ext[8*(PB - 1 - int'(ncnt)) +: 8];
            default: nbyte = '0;
        endcase

`ifdef IPV4_TX_MIN_FRAME_PAD_EN
        nlast = ((nstate == S_PAY) && (ncnt == PB_LAST) && (PAD_BYTES == 0)) ||
                ((nstate == S_PAD) && (ncnt == PAD_LAST));
`else
        nlast = (nstate == S_PAY) && (ncnt == PB_LAST);
`endif
    end

    // Frame sequencer, registered stream outputs, checksum accumulation and counters
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            data_r    <= '0;
            valid_r   <= 1'b0;
            first_r   <= 1'b0;
            last_r    <= 1'b0;
            rfs_r     <= 1'b1;
            pkt_cnt   <= '0;
            ident_r   <= IDENT_INIT;
            dst_mac_r <= '0;
            src_mac_r <= '0;
            dst_ip_r  <= '0;
            src_ip_r  <= '0;
            msg_r     <= '0;
            cks_acc   <= '0;
            cks_idx   <= 4'd10;
        end else begin
            // Fold the end-around carry every cycle so the sum stays 16 bits wide
            if (cks_idx != 4'd10) begin
                cks_acc <= cks_sum[15:0] + {15'd0, cks_sum[16]};
                cks_idx <= cks_idx + 4'd1;
            end

            if (state == S_IDLE) begin
                if (START_IP_TXN) begin
                    dst_mac_r <= RECIPIENT_MAC_ADDRESS;
                    src_mac_r <= ACCELERATOR_MAC_ADDRESS;
                    dst_ip_r  <= RECIPIENT_IP_ADDRESS;
                    src_ip_r  <= ACCELERATOR_IP_ADDRESS;
                    msg_r     <= RECIPIENT_MESSAGE;
                    cks_acc   <= '0;
                    cks_idx   <= '0;
                    state     <= nstate;
                    cnt       <= ncnt;
                    data_r    <= nbyte;
                    valid_r   <= 1'b1;
                    first_r   <= 1'b1;
                    last_r    <= nlast;
                    rfs_r     <= 1'b0;
                end
            end else if (valid_r && MAC_DATA_READY) begin
                if (last_r) begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    valid_r <= 1'b0;
                    first_r <= 1'b0;
                    last_r  <= 1'b0;
                    rfs_r   <= 1'b1;
                    ident_r <= ident_r + 16'd1;
                    pkt_cnt <= pkt_cnt + 16'd1;
                end else begin
                    state   <= nstate;
                    cnt     <= ncnt;
                    data_r  <= nbyte;
                    first_r <= 1'b0;
                    last_r  <= nlast;
                end
            end
        end
    end

endmodule

// File: tb/tb_ipv4_packet_tx_param.sv
// Scoreboard bench for ipv4_packet_tx_param: the driver pushes hand-computed
// frames into a queue, the monitor pops and compares on every transfer.
module tb_ipv4_packet_tx_param;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] ACCELERATOR_IP_ADDRESS;
    logic [47:0] ACCELERATOR_MAC_ADDRESS;
    logic [31:0] RECIPIENT_IP_ADDRESS;
    logic [47:0] RECIPIENT_MAC_ADDRESS;
    logic [9:0]  RECIPIENT_MESSAGE;
    logic        START_IP_TXN;
    logic        READY_FOR_SEND;
    logic [7:0]  MAC_DATA_OUT;
    logic        MAC_DATA_READY;
    logic        MAC_DATA_VALID;
    logic        MAC_DATA_FIRST;
    logic        MAC_DATA_LAST;
    logic [15:0] TX_PACKET_COUNT;

    ipv4_packet_tx_param #(
        .MSG_WIDTH  (10),
        .TTL        (8'h80),
        .PROTOCOL   (8'h04),
        .IDENT_INIT (16'h0)
    ) dut (
        .ACLK                    (ACLK),
        .ARESET                  (ARESET),
        .ACCELERATOR_IP_ADDRESS  (ACCELERATOR_IP_ADDRESS),
        .ACCELERATOR_MAC_ADDRESS (ACCELERATOR_MAC_ADDRESS),
        .RECIPIENT_IP_ADDRESS    (RECIPIENT_IP_ADDRESS),
        .RECIPIENT_MAC_ADDRESS   (RECIPIENT_MAC_ADDRESS),
        .RECIPIENT_MESSAGE       (RECIPIENT_MESSAGE),
        .START_IP_TXN            (START_IP_TXN),
        .READY_FOR_SEND          (READY_FOR_SEND),
        .MAC_DATA_OUT            (MAC_DATA_OUT),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_FIRST          (MAC_DATA_FIRST),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .TX_PACKET_COUNT         (TX_PACKET_COUNT)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    tests = 0;
    int    fails = 0;
    int    byte_idx = 0;
    logic  stall_prev = 1'b0;
    logic [10:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected frame for the fixed test addressing; checksum is supplied precomputed
    task automatic push_frame(input logic [15:0] ident, input logic [15:0] cks);
        logic [7:0] b[$];
        b = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
             8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
             8'h08, 8'h00,
             8'h45, 8'h00, 8'h00, 8'h16, ident[15:8], ident[7:0], 8'h00, 8'h00,
             8'h80, 8'h04, cks[15:8], cks[7:0],
             8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
             8'h02, 8'hA5};
`ifdef IPV4_TX_MIN_FRAME_PAD_EN
        while (b.size() < 60) b.push_back(8'h00);
`endif
        foreach (b[i]) q.push_back('{data: b[i], first: (i == 0), last: (i == b.size() - 1)});
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] ident, input logic [15:0] cks);
        push_frame(ident, cks);
        START_IP_TXN = 1'b1;
        cyc();
        START_IP_TXN = 1'b0;
        check("first_byte_latency", {30'd0, MAC_DATA_VALID, MAC_DATA_FIRST}, 32'd3);
    endtask

    task automatic wait_idle(input bit toggle);
        int n = 0;
        while (!(READY_FOR_SEND && q.size() == 0) && n < 500) begin
            MAC_DATA_READY = toggle ? ~MAC_DATA_READY : 1'b1;
            cyc();
            n++;
        end
        MAC_DATA_READY = 1'b1;
        check("frame_done_in_time", (n < 500) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: pop-and-compare on each transfer, and hold-stability across stalls
    always @(negedge ACLK) begin
        if (ARESET) begin
            stall_prev = 1'b0;
            byte_idx   = 0;
        end else begin
            if (stall_prev)
                check("stall_hold", {21'd0, MAC_DATA_VALID, MAC_DATA_FIRST, MAC_DATA_LAST, MAC_DATA_OUT},
                      {21'd0, held});
            stall_prev = MAC_DATA_VALID && !MAC_DATA_READY;
            held = {MAC_DATA_VALID, MAC_DATA_FIRST, MAC_DATA_LAST, MAC_DATA_OUT};
            if (MAC_DATA_VALID && MAC_DATA_READY) begin
                if (q.size() == 0) begin
                    check("unexpected_byte", {24'd0, MAC_DATA_OUT}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    check($sformatf("byte%0d", byte_idx),
                          {22'd0, MAC_DATA_OUT, MAC_DATA_FIRST, MAC_DATA_LAST},
                          {22'd0, e.data, e.first, e.last});
                    byte_idx = e.last ? 0 : byte_idx + 1;
                end
            end
        end
    end

    initial begin
        ARESET                  = 1'b1;
        ACCELERATOR_IP_ADDRESS  = 32'h0A00_0001;
        ACCELERATOR_MAC_ADDRESS = 48'h02AA_BBCC_DDEE;
        RECIPIENT_IP_ADDRESS    = 32'h0A00_0002;
        RECIPIENT_MAC_ADDRESS   = 48'h0211_2233_4455;
        RECIPIENT_MESSAGE       = 10'h2A5;
        START_IP_TXN            = 1'b0;
        MAC_DATA_READY          = 1'b1;
        cyc(2);
        ARESET = 1'b0;
        cyc();

        check("rst_valid", {31'd0, MAC_DATA_VALID}, 32'd0);
        check("rst_first_last", {30'd0, MAC_DATA_FIRST, MAC_DATA_LAST}, 32'd0);
        check("rst_data", {24'd0, MAC_DATA_OUT}, 32'd0);
        check("rst_ready_for_send", {31'd0, READY_FOR_SEND}, 32'd1);
        check("rst_count", {16'd0, TX_PACKET_COUNT}, 32'd0);

        // Back-to-back packets: ident 0 then 1
        start_frame(16'h0000, 16'h26E2);
        check("busy_not_ready", {31'd0, READY_FOR_SEND}, 32'd0);
        wait_idle(1'b0);
        check("count_after_1", {16'd0, TX_PACKET_COUNT}, 32'd1);
        start_frame(16'h0001, 16'h26E1);
        wait_idle(1'b0);
        check("count_after_2", {16'd0, TX_PACKET_COUNT}, 32'd2);

        // Backpressure: READY toggling every cycle
        start_frame(16'h0002, 16'h26E0);
        wait_idle(1'b1);
        check("count_after_toggle", {16'd0, TX_PACKET_COUNT}, 32'd3);

        // START mid-frame and in the LAST-transfer cycle are both ignored
        start_frame(16'h0003, 16'h26DF);
        cyc(5);
        START_IP_TXN = 1'b1;
        cyc();
        START_IP_TXN = 1'b0;
        begin
            int n = 0;
            while (!(MAC_DATA_VALID && MAC_DATA_LAST) && n < 200) begin cyc(); n++; end
            check("reached_last", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        end
        START_IP_TXN = 1'b1;
        cyc();
        START_IP_TXN = 1'b0;
        check("ready_rises_after_last", {31'd0, READY_FOR_SEND}, 32'd1);
        cyc(3);
        check("no_extra_frame", {31'd0, MAC_DATA_VALID}, 32'd0);
        check("queue_empty_after_ignore", q.size(), 32'd0);
        check("count_after_ignore", {16'd0, TX_PACKET_COUNT}, 32'd4);

        // Reset at IP header byte 5 (frame byte 19)
        start_frame(16'h0004, 16'h26DE);
        cyc(19);
        check("at_ip_byte5", {24'd0, MAC_DATA_OUT}, 32'h00000004);
        ARESET = 1'b1;
        q.delete();
        cyc();
        check("abort_valid", {31'd0, MAC_DATA_VALID}, 32'd0);
        check("abort_ready_for_send", {31'd0, READY_FOR_SEND}, 32'd1);
        ARESET = 1'b0;
        cyc();
        start_frame(16'h0000, 16'h26E2);
        wait_idle(1'b0);
        check("count_after_reset_frame", {16'd0, TX_PACKET_COUNT}, 32'd1);

        cyc(2);
        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
